forward_stall_unit: RTL and testbench

FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

---
 rtl/forward_stall_unit.sv | 121 ++++++++++++
 tb/tb_forward_stall_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_stall_unit
// Description : EX-stage operand forwarding select and hazard stall logic
//               with a long-latency destination scoreboard, WAW conflict
//               pulse and a saturating stall cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_stall_unit #(
  parameter int NUM_SRC = 2,
  parameter int NUM_RD  = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16,
  localparam int SW     = $clog2(NUM_SRC + 2)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*REG_AW-1:0]   rs_ex,
  input  logic [NUM_SRC*REG_AW-1:0]  rd_src,
  input  logic [NUM_SRC-1:0]         wen_src,
  input  logic [NUM_SRC-1:0]         ready_src,
  input  logic                       lng_issue,
  input  logic [REG_AW-1:0]          lng_rd,
  input  logic                       lng_done,
  input  logic [REG_AW-1:0]          lng_done_rd,
  output logic [NUM_RD*SW-1:0]       fwd_sel,
  output logic                       stall,
  output logic [(1<<REG_AW)-1:0]     pending,
  output logic                       sb_conflict,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int             NREG    = 1 << REG_AW;
  localparam logic [SW-1:0]  C_SEL_LNG = SW'(NUM_SRC + 1);

  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pend_next;
  logic              r_conflict;
  logic              w_conflict;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_RD-1:0] w_port_stall;

  // Per read port: choose the operand source and decide whether it must wait
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [REG_AW-1:0] w_rs;
    logic [SW-1:0]     w_sel;
    logic              w_not_ready;
    logic              w_stall;

    assign w_rs = rs_ex[p*REG_AW +: REG_AW];

    // Youngest matching source wins (descending scan, last hit kept);
    // the long result bus is only a fallback when no pipeline source hits.
    always_comb begin
      w_sel       = '0;
      w_not_ready = 1'b0;
      w_stall     = 1'b0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        if ((w_rs != '0) && wen_src[k] &&
            (rd_src[k*REG_AW +: REG_AW] == w_rs)) begin
          w_sel       = SW'(k + 1);
          w_not_ready = !ready_src[k];
        end
      end
      if ((w_sel == '0) && (w_rs != '0) && lng_done && (lng_done_rd == w_rs)) begin
        w_sel = C_SEL_LNG;
      end
      // Register x0 never stalls because its scoreboard bit is tied low
      w_stall = w_not_ready || ((w_sel == '0) && r_pending[w_rs]);
    end

    assign fwd_sel[p*SW +: SW] = w_sel;
    assign w_port_stall[p]     = w_stall;
  end

  assign stall = |w_port_stall;

  // Scoreboard next state: completion clears first so a same-cycle issue wins
  always_comb begin
    w_pend_next = r_pending;
    if (lng_done) begin
      w_pend_next[lng_done_rd] = 1'b0;
    end
    if (lng_issue && (lng_rd != '0)) begin
      w_pend_next[lng_rd] = 1'b1;
    end
    w_pend_next[0] = 1'b0;
  end

  // WAW issue onto a register still awaiting its earlier long result
  always_comb begin
    w_conflict = lng_issue && (lng_rd != '0) && r_pending[lng_rd] &&
                 !(lng_done && (lng_done_rd == lng_rd));
  end

  // Scoreboard and conflict pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_pending  <= w_pend_next;
      r_conflict <= w_conflict;
    end
  end

  // Saturating count of cycles spent stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign pending     = r_pending;
  assign sb_conflict = r_conflict;
  assign stall_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forward_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_stall_unit
// Description : Self-checking bench for forward_stall_unit using a
//               behavioural model plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_stall_unit;

  localparam int NUM_SRC = 2;
  localparam int NUM_RD  = 2;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 16;
  localparam int SW      = 2;
  localparam int NREG    = 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_RD*REG_AW-1:0]   rs_ex;
  logic [NUM_SRC*REG_AW-1:0]  rd_src;
  logic [NUM_SRC-1:0]         wen_src;
  logic [NUM_SRC-1:0]         ready_src;
  logic                       lng_issue;
  logic [REG_AW-1:0]          lng_rd;
  logic                       lng_done;
  logic [REG_AW-1:0]          lng_done_rd;
  logic [NUM_RD*SW-1:0]       fwd_sel;
  logic                       stall;
  logic [NREG-1:0]            pending;
  logic                       sb_conflict;
  logic [CNT_W-1:0]           stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit [NREG-1:0] m_pend = '0;
  bit            m_conf = 1'b0;
  int            m_cnt  = 0;

  forward_stall_unit #(
    .NUM_SRC(NUM_SRC), .NUM_RD(NUM_RD), .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs_ex(rs_ex), .rd_src(rd_src),
    .wen_src(wen_src), .ready_src(ready_src), .lng_issue(lng_issue),
    .lng_rd(lng_rd), .lng_done(lng_done), .lng_done_rd(lng_done_rd),
    .fwd_sel(fwd_sel), .stall(stall), .pending(pending),
    .sb_conflict(sb_conflict), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int rs0, input int rs1, input int rd0, input int rd1,
                        input int wen, input int rdy, input int iss, input int iss_rd,
                        input int dn, input int dn_rd);
    rs_ex       = {REG_AW'(rs1), REG_AW'(rs0)};
    rd_src      = {REG_AW'(rd1), REG_AW'(rd0)};
    wen_src     = NUM_SRC'(wen);
    ready_src   = NUM_SRC'(rdy);
    lng_issue   = iss[0];
    lng_rd      = REG_AW'(iss_rd);
    lng_done    = dn[0];
    lng_done_rd = REG_AW'(dn_rd);
  endtask

  // Expected select / stall from the forwarding rules
  task automatic model_comb(output logic [NUM_RD*SW-1:0] sel, output logic st);
    sel = '0;
    st  = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      int rs;
      int s;
      rs = int'(rs_ex[p*REG_AW +: REG_AW]);
      s  = 0;
      if (rs != 0) begin
        for (int k = 0; k < NUM_SRC; k++)
          if (s == 0 && wen_src[k] && int'(rd_src[k*REG_AW +: REG_AW]) == rs) s = k + 1;
        if (s == 0 && lng_done && int'(lng_done_rd) == rs) s = NUM_SRC + 1;
      end
      if (s >= 1 && s <= NUM_SRC && !ready_src[s-1]) st = 1'b1;
      if (s == 0 && m_pend[rs]) st = 1'b1;
      sel[p*SW +: SW] = SW'(s);
    end
  endtask

  // Compare every output against the model, then advance one clock
  task automatic cycle();
    logic [NUM_RD*SW-1:0] es;
    logic                 est;
    bit                   nc;
    #1;
    model_comb(es, est);
    chk("fwd_sel", 64'(fwd_sel), 64'(es));
    chk("stall", 64'(stall), 64'(est));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("sb_conflict", 64'(sb_conflict), 64'(m_conf));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    @(posedge clk);
    nc = lng_issue && lng_rd != 0 && m_pend[lng_rd] && !(lng_done && lng_done_rd == lng_rd);
    if (lng_done) m_pend[lng_done_rd] = 1'b0;
    if (lng_issue && lng_rd != 0) m_pend[lng_rd] = 1'b1;
    m_conf = nc;
    if (est && m_cnt < CNT_MAX) m_cnt++;
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("reset_pending", 64'(pending), 64'd0);
    chk("reset_conflict", 64'(sb_conflict), 64'd0);
    chk("reset_cnt", 64'(stall_cnt), 64'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    #1;
    chk("idle_sel", 64'(fwd_sel), 64'd0);
    chk("idle_stall", 64'(stall), 64'd0);
    cycle();

    // Both ports forward from distinct sources
    set_in(5, 6, 5, 6, 3, 3, 0, 0, 0, 0);
    #1;
    chk("fwd_two_src_sel", 64'(fwd_sel), 64'h9);
    chk("fwd_two_src_stall", 64'(stall), 64'd0);
    cycle();

    // Load-use: youngest source matches but is not ready
    set_in(7, 0, 7, 7, 3, 2, 0, 0, 0, 0);
    #1;
    chk("load_use_sel", 64'(fwd_sel), 64'h1);
    chk("load_use_stall", 64'(stall), 64'd1);
    cycle();
    set_in(7, 0, 7, 7, 3, 3, 0, 0, 0, 0);
    #1;
    chk("load_ready_stall", 64'(stall), 64'd0);
    chk("load_ready_cnt", 64'(stall_cnt), 64'd1);
    cycle();

    // Long-latency issue, dependent stall, bypass on completion
    set_in(0, 0, 0, 0, 0, 3, 1, 9, 0, 0);
    cycle();
    set_in(9, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    #1;
    chk("lng_dep_stall", 64'(stall), 64'd1);
    chk("lng_pending9", 64'(pending[9]), 64'd1);
    cycle();
    set_in(9, 0, 0, 0, 0, 3, 0, 0, 1, 9);
    #1;
    chk("lng_bypass_sel", 64'(fwd_sel), 64'h3);
    chk("lng_bypass_stall", 64'(stall), 64'd0);
    cycle();
    idle();
    #1;
    chk("lng_cleared", 64'(pending[9]), 64'd0);
    cycle();

    // WAW conflict pulse, then same-cycle issue+done keeps pending set
    set_in(0, 0, 0, 0, 0, 3, 1, 9, 0, 0);
    cycle();
    cycle();
    set_in(0, 0, 0, 0, 0, 3, 1, 9, 1, 9);
    #1;
    chk("waw_conflict", 64'(sb_conflict), 64'd1);
    cycle();
    idle();
    #1;
    chk("issue_done_pending9", 64'(pending[9]), 64'd1);
    chk("conflict_one_cycle", 64'(sb_conflict), 64'd0);
    cycle();
    set_in(0, 0, 0, 0, 0, 3, 0, 0, 1, 9);
    cycle();

    // Register zero is never forwarded nor tracked
    set_in(0, 0, 0, 0, 3, 3, 1, 0, 0, 0);
    #1;
    chk("x0_sel", 64'(fwd_sel), 64'd0);
    chk("x0_stall", 64'(stall), 64'd0);
    cycle();
    idle();
    #1;
    chk("x0_pending", 64'(pending), 64'd0);
    cycle();

    // Randomized traffic on a small register window to provoke collisions
    for (int i = 0; i < 2000; i++) begin
      set_in(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 3,
             ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 7)));
      cycle();
    end

    // Hold a stall long enough to saturate the counter
    set_in(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    for (int r = 1; r < NREG; r++) begin
      set_in(0, 0, 0, 0, 0, 3, 0, 0, 1, r);
      cycle();
    end
    set_in(7, 0, 7, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < CNT_MAX + 4; i++) cycle();
    #1;
    chk("cnt_saturated", 64'(stall_cnt), 64'(CNT_MAX));

    // Asynchronous reset mid-operation
    set_in(0, 0, 0, 0, 0, 3, 1, 12, 0, 0);
    cycle();
    idle();
    #1;
    chk("pre_reset_pending12", 64'(pending[12]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pending", 64'(pending), 64'd0);
    chk("async_rst_conflict", 64'(sb_conflict), 64'd0);
    chk("async_rst_cnt", 64'(stall_cnt), 64'd0);
    m_pend = '0;
    m_conf = 1'b0;
    m_cnt  = 0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
